// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// FSM state constants and default latencies.
package e_mdu_pkg;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t MDU_NONE  = 4'd0;
  localparam mdu_op_t MDU_MULT  = 4'd1;
  localparam mdu_op_t MDU_MULTU = 4'd2;
  localparam mdu_op_t MDU_DIV   = 4'd3;
  localparam mdu_op_t MDU_DIVU  = 4'd4;
  localparam mdu_op_t MDU_MFHI  = 4'd5;
  localparam mdu_op_t MDU_MFLO  = 4'd6;
  localparam mdu_op_t MDU_MTHI  = 4'd7;
  localparam mdu_op_t MDU_MTLO  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_start_op(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU signal bundle; master is the E stage, slave is the MDU.
interface e_mdu_if;

  e_mdu_pkg::mdu_op_t E_MDU_Op;
  logic [31:0]        E_RS;
  logic [31:0]        E_RT;
  logic               E_MDU_Start;
  logic               E_MDU_Busy;
  logic [31:0]        E_MDU_Result;
  logic [31:0]        E_HI;
  logic [31:0]        E_LO;

  modport master (
    output E_MDU_Op, E_RS, E_RT,
    input  E_MDU_Start, E_MDU_Busy, E_MDU_Result, E_HI, E_LO
  );

  modport slave (
    input  E_MDU_Op, E_RS, E_RT,
    output E_MDU_Start, E_MDU_Busy, E_MDU_Result, E_HI, E_LO
  );

endinterface

// File: rtl/e_mdu_arith.sv
// Combinational MDU datapath: {hi, lo} for MULT/MULTU/DIV/DIVU plus a
// divide-by-zero flag. Isolated so an iterative divider can drop in later.
module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] hilo,
  output logic        div_zero
);

  // The single overflowing case (-2^31 / -1) is pinned to the MIPS result.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if ((a == 32'sh80000000) && (b == -32'sd1))
      return {32'h0000_0000, 32'h8000_0000};
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  logic               rt_zero;
  logic [31:0]        rt_nz;
  logic signed [63:0] rs_sx;
  logic signed [63:0] rt_sx;

  assign rt_zero  = (rt == 32'd0);
  assign rt_nz    = rt_zero ? 32'd1 : rt;
  assign div_zero = is_div_op(op) && rt_zero;
  assign rs_sx    = {{32{rs[31]}}, rs};
  assign rt_sx    = {{32{rt[31]}}, rt};

  always_comb begin
    hilo = 64'd0;
    case (op)
      MDU_MULT:  hilo = rs_sx * rt_sx;
      MDU_MULTU: hilo = {32'd0, rs} * {32'd0, rt};
      MDU_DIV:   hilo = div_signed(rs, rt_nz);
      MDU_DIVU:  hilo = {rs % rt_nz, rs / rt_nz};
      default:   hilo = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs a fixed-latency IDLE/BUSY
// sequence per MULT/DIV and serves MFHI/MFLO/MTHI/MTLO.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  mdu
);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] s_hi;
  logic [31:0] s_lo;
  logic        s_dz;
  logic [63:0] arith_hilo;
  logic        arith_dz;
  logic        start;

  e_mdu_arith u_arith (
    .op       (mdu.E_MDU_Op),
    .rs       (mdu.E_RS),
    .rt       (mdu.E_RT),
    .hilo     (arith_hilo),
    .div_zero (arith_dz)
  );

  assign start = is_start_op(mdu.E_MDU_Op) && (state == ST_IDLE);

  // Result is captured at launch; HI/LO only change on the final busy edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      s_hi  <= 32'd0;
      s_lo  <= 32'd0;
      s_dz  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        s_hi  <= arith_hilo[63:32];
        s_lo  <= arith_hilo[31:0];
        s_dz  <= arith_dz;
        cnt   <= is_div_op(mdu.E_MDU_Op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        state <= ST_BUSY;
      end else if (mdu.E_MDU_Op == MDU_MTHI) begin
        hi <= mdu.E_RS;
      end else if (mdu.E_MDU_Op == MDU_MTLO) begin
        lo <= mdu.E_RS;
      end
    end else begin
      if (cnt == 4'd1) begin
        if (!s_dz) begin
          hi <= s_hi;
          lo <= s_lo;
        end
        cnt   <= 4'd0;
        state <= ST_IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    mdu.E_MDU_Result = 32'd0;
    if (mdu.E_MDU_Op == MDU_MFHI)
      mdu.E_MDU_Result = hi;
    else if (mdu.E_MDU_Op == MDU_MFLO)
      mdu.E_MDU_Result = lo;
  end

  assign mdu.E_MDU_Start = start;
  assign mdu.E_MDU_Busy  = (state == ST_BUSY);
  assign mdu.E_HI        = hi;
  assign mdu.E_LO        = lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: table of MULT/DIV vectors plus hand sequences
// for async reset, divide-by-zero and requests arriving while busy.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  typedef struct {
    mdu_op_t     op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs [10];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mdu_op_t op, input logic [31:0] rs, input logic [31:0] rt);
    bus.E_MDU_Op = op;
    bus.E_RS     = rs;
    bus.E_RT     = rt;
    #1;
  endtask

  // Launch one op at cycle 0, expect busy for cycles 1..n, old LO on MFLO in
  // cycle n, and the new HI/LO from cycle n+1.
  task automatic run_op(input mdu_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int n;
    int busy_bad;
    n        = ((op == MDU_MULT) || (op == MDU_MULTU)) ? MC : DC;
    busy_bad = 0;
    drive(op, rs, rt);
    chk($sformatf("%s_start", tag), 32'(bus.E_MDU_Start), 32'd1);
    tick();
    for (int i = 1; i <= n; i++) begin
      drive((i == n) ? MDU_MFLO : MDU_NONE, 32'd0, 32'd0);
      if (bus.E_MDU_Busy !== 1'b1) busy_bad++;
      if (i == n) chk($sformatf("%s_mflo_precommit", tag), bus.E_MDU_Result, m_lo);
      tick();
    end
    chk($sformatf("%s_busy_window_errs", tag), 32'(busy_bad), 32'd0);
    drive(MDU_MFHI, 32'd0, 32'd0);
    chk($sformatf("%s_busy_after", tag), 32'(bus.E_MDU_Busy), 32'd0);
    chk($sformatf("%s_mfhi", tag), bus.E_MDU_Result, exp_hi);
    chk($sformatf("%s_hi", tag), bus.E_HI, exp_hi);
    chk($sformatf("%s_lo", tag), bus.E_LO, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
    drive(MDU_NONE, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    int start_bad;
    int busy_bad;

    vecs[0] = '{MDU_MULT,  32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999};
    vecs[6] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[8] = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[9] = '{MDU_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

    // Reset state
    reset = 1'b0;
    drive(MDU_NONE, 32'd0, 32'd0);
    chk("rst_hi", bus.E_HI, 32'd0);
    chk("rst_lo", bus.E_LO, 32'd0);
    chk("rst_busy", 32'(bus.E_MDU_Busy), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // MTLO then asynchronous reset with no clock edge
    drive(MDU_MTLO, 32'h1234, 32'd0);
    tick();
    drive(MDU_NONE, 32'd0, 32'd0);
    chk("mtlo_lo", bus.E_LO, 32'h1234);
    reset = 1'b0;
    #1;
    chk("async_rst_lo", bus.E_LO, 32'd0);
    chk("async_rst_hi", bus.E_HI, 32'd0);
    chk("async_rst_busy", 32'(bus.E_MDU_Busy), 32'd0);
    reset = 1'b1;
    tick();
    m_hi = 32'd0;
    m_lo = 32'd0;

    // Op code outside the package set behaves as NONE
    drive(4'hF, 32'd5, 32'd6);
    chk("badop_start", 32'(bus.E_MDU_Start), 32'd0);
    chk("badop_result", bus.E_MDU_Result, 32'd0);
    tick();
    drive(MDU_NONE, 32'd0, 32'd0);
    chk("badop_busy", 32'(bus.E_MDU_Busy), 32'd0);
    chk("badop_lo", bus.E_LO, 32'd0);
    tick();

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Divide by zero leaves preloaded HI/LO untouched
    drive(MDU_MTHI, 32'hAA, 32'd0);
    tick();
    drive(MDU_MTLO, 32'hBB, 32'd0);
    tick();
    drive(MDU_NONE, 32'd0, 32'd0);
    chk("preload_hi", bus.E_HI, 32'hAA);
    chk("preload_lo", bus.E_LO, 32'hBB);
    m_hi = 32'hAA;
    m_lo = 32'hBB;
    tick();
    run_op(MDU_DIVU, 32'd7, 32'd0, 32'hAA, 32'hBB, "divz");

    // MULT and MTHI arriving while a DIV is in flight are ignored
    start_bad = 0;
    busy_bad  = 0;
    drive(MDU_DIV, 32'd100, 32'd7);
    chk("ovl_start", 32'(bus.E_MDU_Start), 32'd1);
    tick();
    for (int i = 1; i <= DC; i++) begin
      if (i <= 3)      drive(MDU_MULT, 32'd3, 32'd3);
      else if (i == 4) drive(MDU_MTHI, 32'hDEAD, 32'd0);
      else             drive(MDU_NONE, 32'd0, 32'd0);
      if (bus.E_MDU_Start !== 1'b0) start_bad++;
      if (bus.E_MDU_Busy !== 1'b1) busy_bad++;
      if (i == 5) chk("ovl_hi_after_mthi", bus.E_HI, m_hi);
      tick();
    end
    drive(MDU_NONE, 32'd0, 32'd0);
    chk("ovl_start_errs", 32'(start_bad), 32'd0);
    chk("ovl_busy_errs", 32'(busy_bad), 32'd0);
    chk("ovl_busy_after", 32'(bus.E_MDU_Busy), 32'd0);
    chk("ovl_hi", bus.E_HI, 32'd2);
    chk("ovl_lo", bus.E_LO, 32'd14);
    tick();

    // Reset in the middle of a MULT discards it
    drive(MDU_MULT, 32'd5, 32'd5);
    tick();
    drive(MDU_NONE, 32'd0, 32'd0);
    tick();
    chk("midop_busy_before", 32'(bus.E_MDU_Busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midop_rst_busy", 32'(bus.E_MDU_Busy), 32'd0);
    chk("midop_rst_hi", bus.E_HI, 32'd0);
    reset = 1'b1;
    repeat (MC + 2) tick();
    chk("midop_after_lo", bus.E_LO, 32'd0);
    chk("midop_after_busy", 32'(bus.E_MDU_Busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
